wb_rom_port: RTL

Wishbone-slave program ROM for the 4ft4 system. Caravel's management core loads 4-bit-CPU program bytes over Wishbone; the CPU side fetches a byte and receives it as two sequential nibbles (high then low), matching the 4004-style two-phase instruction fetch. The block sits inside `wb_system` between the Wishbone port and the CPU core, and drives the system's `rom_out` byte.

---
 rtl/rom_port_pkg.sv | 22 ++
 rtl/rom_mem_256x8.sv | 33 +++
 rtl/wb_rom_port.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rom_port_pkg.sv
// Shared constants and FSM state types for the 4ft4 Wishbone program ROM port.
package rom_port_pkg;

    localparam int         ROM_DEPTH     = 256;
    localparam logic [8:0] CTRL_OFFSET   = 9'h100;
    localparam int         CTRL_RUN_BIT  = 0;
    localparam int         CTRL_BUSY_BIT = 1;
    localparam int         CTRL_CNT_LSB  = 8;
    localparam int         CTRL_CNT_MSB  = 15;

    typedef enum logic {
        WB_IDLE,
        WB_ACK
    } wb_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_HI,
        SEQ_LO
    } seq_state_t;

endpackage

// File: rtl/rom_mem_256x8.sv
// 256x8 program store: byte-lane write port, async Wishbone word read, async CPU byte read.
module rom_mem_256x8
    import rom_port_pkg::*;
(
    input  logic        clock,
    input  logic        wr_en,
    input  logic [5:0]  wr_word,
    input  logic [3:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [5:0]  wb_rd_word,
    output logic [31:0] wb_rd_data,
    input  logic [7:0]  cpu_addr,
    output logic [7:0]  cpu_data
);

    logic [7:0] mem [ROM_DEPTH];

    // No reset on the array so it can be swapped for a hard macro.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int n = 0; n < 4; n++) begin
                if (wr_sel[n]) begin
                    mem[{wr_word, 2'(n)}] <= wr_data[8*n +: 8];
                end
            end
        end
    end

    assign wb_rd_data = {mem[{wb_rd_word, 2'd3}], mem[{wb_rd_word, 2'd2}],
                         mem[{wb_rd_word, 2'd1}], mem[{wb_rd_word, 2'd0}]};
    assign cpu_data   = mem[cpu_addr];

endmodule

// File: rtl/wb_rom_port.sv
// Wishbone-loaded program ROM with a two-nibble CPU fetch sequencer.
// Optional macro ROM_WB_READBACK_EN enables Wishbone readback of ROM contents.
module wb_rom_port
    import rom_port_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wb_cyc_i,
    input  logic        wb_strobe_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    input  logic        cpu_fetch_i,
    input  logic [7:0]  cpu_addr_i,
    output logic [3:0]  nibble_o,
    output logic        nibble_valid_o,
    output logic [7:0]  rom_out
);

    wb_state_t  wb_state, wb_state_next;
    seq_state_t seq_state, seq_state_next;

    logic        run;
    logic [7:0]  fetch_count;
    logic        busy;
    logic        wb_hit, rom_sel, ctrl_sel;
    logic        wb_req, mem_we, ctrl_wr, fetch_ok;
    logic [31:0] mem_rd_data, rom_rd_data, rd_data;
    logic [7:0]  cpu_byte;
    logic        unused_bits;

    assign wb_hit   = (wb_addr_i[31:9] == ADDR_BASE[31:9]);
    assign rom_sel  = ~wb_addr_i[8];
    assign ctrl_sel = (wb_addr_i[8:0] == CTRL_OFFSET);
    assign busy     = (seq_state != SEQ_IDLE);

    rom_mem_256x8 u_mem (
        .clock      (clock),
        .wr_en      (mem_we),
        .wr_word    (wb_addr_i[7:2]),
        .wr_sel     (wb_sel_i),
        .wr_data    (wb_data_i),
        .wb_rd_word (wb_addr_i[7:2]),
        .wb_rd_data (mem_rd_data),
        .cpu_addr   (cpu_addr_i),
        .cpu_data   (cpu_byte)
    );

`ifdef ROM_WB_READBACK_EN
    assign rom_rd_data = mem_rd_data;
    assign unused_bits = ^wb_addr_i[1:0];
`else
    assign rom_rd_data = '0;
    assign unused_bits = ^{wb_addr_i[1:0], mem_rd_data};
`endif

    always_comb begin
        wb_state_next = wb_state;
        wb_req        = 1'b0;
        case (wb_state)
            WB_IDLE: begin
                if (wb_cyc_i && wb_strobe_i && wb_hit) begin
                    wb_req        = 1'b1;
                    wb_state_next = WB_ACK;
                end
            end
            default: wb_state_next = WB_IDLE;
        endcase
    end

    assign mem_we  = wb_req & wb_we_i & rom_sel;
    assign ctrl_wr = wb_req & wb_we_i & ctrl_sel;

    always_comb begin
        rd_data = '0;
        if (rom_sel) begin
            rd_data = rom_rd_data;
        end else if (ctrl_sel) begin
            rd_data[CTRL_RUN_BIT]               = run;
            rd_data[CTRL_BUSY_BIT]              = busy;
            rd_data[CTRL_CNT_MSB:CTRL_CNT_LSB]  = fetch_count;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wb_state  <= WB_IDLE;
            wb_data_o <= '0;
        end else begin
            wb_state  <= wb_state_next;
            wb_data_o <= (wb_req && !wb_we_i) ? rd_data : '0;
        end
    end

    assign wb_ack_o = (wb_state == WB_ACK);

    // A fetch in SEQ_LO chains straight into the next pair; only SEQ_HI rejects.
    always_comb begin
        seq_state_next = seq_state;
        fetch_ok       = 1'b0;
        nibble_o       = 4'h0;
        nibble_valid_o = 1'b0;
        case (seq_state)
            SEQ_HI: begin
                nibble_o       = rom_out[7:4];
                nibble_valid_o = 1'b1;
                seq_state_next = SEQ_LO;
            end
            SEQ_LO: begin
                nibble_o       = rom_out[3:0];
                nibble_valid_o = 1'b1;
                if (cpu_fetch_i && run) begin
                    fetch_ok       = 1'b1;
                    seq_state_next = SEQ_HI;
                end else begin
                    seq_state_next = SEQ_IDLE;
                end
            end
            default: begin
                if (cpu_fetch_i && run) begin
                    fetch_ok       = 1'b1;
                    seq_state_next = SEQ_HI;
                end else begin
                    seq_state_next = SEQ_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seq_state   <= SEQ_IDLE;
            rom_out     <= '0;
            run         <= 1'b0;
            fetch_count <= '0;
        end else begin
            seq_state <= seq_state_next;
            if (fetch_ok) begin
                rom_out <= cpu_byte;
            end
            if (ctrl_wr && wb_sel_i[0]) begin
                run <= wb_data_i[CTRL_RUN_BIT];
            end
            // A CTRL write clears the counter even when a fetch lands on the same edge.
            if (ctrl_wr) begin
                fetch_count <= '0;
            end else if (fetch_ok) begin
                fetch_count <= fetch_count + 8'd1;
            end
        end
    end

endmodule
